seq_restoring_divider: RTL and testbench



---
 rtl/arith_pkg.sv | 19 +
 rtl/ripple_subtractor.sv | 24 ++
 rtl/seq_restoring_divider.sv | 154 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic library: divider FSM states and
// the helper that sizes the divider step counter.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Step counter width for a given operand width; must hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ripple_subtractor.sv
// N-bit ripple-borrow subtractor (Diff = A - B - Bin) built from
// full-subtractor cells; Bout is the final borrow out of the MSB.
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] Diff,
  output logic         Bout
);

  logic [N:0] w_borrow;

  assign w_borrow[0] = Bin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign Diff[i]       = A[i] ^ B[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_borrow[i]);
  end

  assign Bout = w_borrow[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// valid/ready handshakes on both the operand and the result side.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvsr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_unused_rem_msb;

  assign w_rs = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

  // A restoring step always leaves R below the divisor, so R[WIDTH] stays zero.
  assign w_unused_rem_msb = r_rem[WIDTH];

  ripple_subtractor #(.N(WIDTH + 1)) u_sub (
    .A    (w_rs),
    .B    ({1'b0, r_dvsr}),
    .Bin  (1'b0),
    .Diff (w_trial),
    .Bout (w_borrow)
  );

  // Restore decision and quotient shift for the current step.
  always_comb begin
    w_rem_nxt = w_trial;
    w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
    if (w_borrow) begin
      w_rem_nxt = w_rs;
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
    end else begin
      w_rem_nxt = w_trial;
      w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = (divisor == {WIDTH{1'b0}}) ? DONE : CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_dvsr <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rem  <= '0;
            r_q    <= dividend;
            r_dvsr <= divisor;
            r_cnt  <= CNT_W'(WIDTH - 1);
            // Division by zero bypasses CALC and publishes its result at once.
            if (divisor == {WIDTH{1'b0}}) begin
              r_quot <= {WIDTH{1'b1}};
              r_remo <= dividend;
              r_dz   <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_quot <= w_q_nxt;
            r_remo <= w_rem_nxt[WIDTH-1:0];
            r_dz   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_rem <= r_rem;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed table at WIDTH=4,
// handshake/reset corner sequences, exhaustive 4-bit and random 8-bit sweeps.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic       in_ready, out_valid, div_by_zero;
  logic [3:0] quotient, remainder;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] dividend8 = '0, divisor8 = '0;
  logic       in_ready8, out_valid8, div_by_zero8;
  logic [7:0] quotient8, remainder8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  seq_restoring_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8),
    .out_ready(out_ready8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(div_by_zero8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic start4(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait4(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    chk("in_ready8_before_accept", {31'd0, in_ready8}, 32'd1);
    in_valid8 = 1'b1; dividend8 = a; divisor8 = b;
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic wait8(output int edges);
    edges = 1;
    while (!out_valid8 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int stall;
    logic [3:0] eq, er;
    logic       edz;
    logic [7:0] a8, b8, eq8, er8;

    vecs[0] = '{4'd13, 4'd4, 4'd3,  4'd1, 1'b0};
    vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    vecs[2] = '{4'd3,  4'd7, 4'd0,  4'd3, 1'b0};
    vecs[3] = '{4'd0,  4'd5, 4'd0,  4'd0, 1'b0};
    vecs[4] = '{4'd9,  4'd0, 4'd15, 4'd9, 1'b1};
    vecs[5] = '{4'd14, 4'd3, 4'd4,  4'd2, 1'b0};
    vecs[6] = '{4'd7,  4'd7, 4'd1,  4'd0, 1'b0};
    vecs[7] = '{4'd15, 4'd2, 4'd7,  4'd1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_quotient",  {28'd0, quotient},    32'd0);
    chk("rst_remainder", {28'd0, remainder},   32'd0);
    chk("rst_dz",        {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    // Directed table, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start4(vecs[i].a, vecs[i].b);
      wait4(e);
      chk("tbl_latency",  e, (vecs[i].b == 4'd0) ? 32'd1 : 32'd5);
      chk("tbl_quotient", {28'd0, quotient},    {28'd0, vecs[i].q});
      chk("tbl_remainder",{28'd0, remainder},   {28'd0, vecs[i].r});
      chk("tbl_dz",       {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
      @(negedge clk);
      chk("tbl_valid_one_cycle", {31'd0, out_valid}, 32'd0);
      chk("tbl_ready_after",     {31'd0, in_ready},  32'd1);
    end

    // 14/3 with backpressure and in_valid pulses during CALC/DONE
    out_ready = 1'b0;
    start4(4'd14, 4'd3);
    e = 1;
    while (!out_valid && e < 40) begin
      in_valid = e[0]; dividend = 4'd15; divisor = 4'd1;
      @(negedge clk);
      e++;
    end
    chk("bp_latency", e, 32'd5);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; dividend = 4'd15; divisor = 4'd0;
      chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_quotient",   {28'd0, quotient},  32'd4);
      chk("bp_remainder",  {28'd0, remainder}, 32'd2);
      chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
      @(negedge clk);
    end
    chk("bp_quotient_end",  {28'd0, quotient},  32'd4);
    chk("bp_remainder_end", {28'd0, remainder}, 32'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready},  32'd1);
    chk("bp_hold_quotient", {28'd0, quotient},  32'd4);

    // Reset on the second CALC cycle of 12/5
    start4(4'd12, 4'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_quotient",  {28'd0, quotient},  32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    start4(4'd12, 4'd5);
    wait4(e);
    chk("after_abort_latency",   e, 32'd5);
    chk("after_abort_quotient",  {28'd0, quotient},  32'd2);
    chk("after_abort_remainder", {28'd0, remainder}, 32'd2);
    @(negedge clk);

    // Exhaustive WIDTH=4 sweep with random result stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        out_ready = 1'($urandom_range(0, 1));
        start4(4'(a), 4'(b));
        wait4(e);
        out_ready = 1'b0;
        if (b == 0) begin
          eq = 4'hF; er = 4'(a); edz = 1'b1;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); edz = 1'b0;
        end
        chk("sweep4_result", {23'd0, div_by_zero, quotient, remainder}, {23'd0, edz, eq, er});
        stall = $urandom_range(0, 2);
        repeat (stall) @(negedge clk);
        chk("sweep4_stable", {22'd0, out_valid, div_by_zero, quotient, remainder},
            {22'd0, 1'b1, edz, eq, er});
        out_ready = 1'b1;
        @(negedge clk);
        chk("sweep4_release", {31'd0, out_valid}, 32'd0);
      end
    end

    // Random WIDTH=8 pairs, including forced corner operands
    for (int n = 0; n < 200; n++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = (n % 17 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (n == 1) begin a8 = 8'd255; b8 = 8'd1;   end
      if (n == 2) begin a8 = 8'd200; b8 = 8'd13;  end
      if (n == 3) begin a8 = 8'd5;   b8 = 8'd255; end
      out_ready8 = 1'b0;
      start8(a8, b8);
      wait8(e);
      if (b8 == 8'd0) begin
        eq8 = 8'hFF; er8 = a8; edz = 1'b1;
      end else begin
        eq8 = a8 / b8; er8 = a8 % b8; edz = 1'b0;
      end
      chk("sweep8_latency", e, (b8 == 8'd0) ? 32'd1 : 32'd9);
      chk("sweep8_result", {15'd0, div_by_zero8, quotient8, remainder8}, {15'd0, edz, eq8, er8});
      stall = $urandom_range(0, 2);
      repeat (stall) @(negedge clk);
      out_ready8 = 1'b1;
      @(negedge clk);
      chk("sweep8_release", {31'd0, out_valid8}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
